// File: rtl/tx_stream_if.sv
// Stream bundle between NUM_PORTS packet sources, the TX arbiter and the MAC TX interface.
// master: the sources/TX side of the bundle; slave: the arbiter's view.
interface tx_stream_if #(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 64
);
   localparam int KEEP_WIDTH = DATA_WIDTH / 8;

   logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata;
   logic [NUM_PORTS*KEEP_WIDTH-1:0] s_axis_tkeep;
   logic [NUM_PORTS-1:0]            s_axis_tvalid;
   logic [NUM_PORTS-1:0]            s_axis_tlast;
   logic [NUM_PORTS-1:0]            s_axis_tready;
   logic [DATA_WIDTH-1:0]           m_axis_tdata;
   logic [KEEP_WIDTH-1:0]           m_axis_tkeep;
   logic                            m_axis_tvalid;
   logic                            m_axis_tlast;
   logic                            m_axis_tready;

   modport master (
      output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_tready,
      input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
   );

   modport slave (
      input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_tready,
      output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
   );
endinterface

// File: rtl/tx_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing the MAC TX path; a grant is held from first beat to tlast.
// Optional per-port packet counters on output pkt_cnt when TX_ARB_STATS_EN is defined.
module tx_stream_arbiter #(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 64
) (
   input  logic                         user_clk,
   input  logic                         aresetn,
   input  logic [NUM_PORTS-1:0]         port_en,
   tx_stream_if.slave                   axis,
   output logic [$clog2(NUM_PORTS)-1:0] grant_id,
   output logic                         busy
`ifdef TX_ARB_STATS_EN
   ,
   output logic [NUM_PORTS*32-1:0]      pkt_cnt
`endif
);
   localparam int              KEEP_WIDTH = DATA_WIDTH / 8;
   localparam int              GW         = $clog2(NUM_PORTS);
   localparam logic [GW-1:0]   LAST_PORT  = GW'(NUM_PORTS - 1);
   localparam logic [GW:0]     NP_W       = (GW+1)'(NUM_PORTS);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [GW-1:0]       grant_q, grant_d;
   logic [GW-1:0]       last_grant_q, last_grant_d;
   logic [GW-1:0]       winner_s;
   logic [GW:0]         cand_s;
   logic [NUM_PORTS-1:0] req_s;
   logic                found_s;
   logic                eop_s;

   // Circular search from last_grant+1; the extra index bit keeps the wrap exact for any NUM_PORTS.
   always_comb begin
      req_s    = axis.s_axis_tvalid & port_en;
      found_s  = 1'b0;
      winner_s = last_grant_q;
      cand_s   = '0;
      for (int off = 1; off <= NUM_PORTS; off++) begin
         cand_s = {1'b0, last_grant_q} + (GW+1)'(off);
         if (cand_s >= NP_W) begin
            cand_s = cand_s - NP_W;
         end else begin
            cand_s = cand_s;
         end
         if (!found_s && req_s[cand_s[GW-1:0]]) begin
            found_s  = 1'b1;
            winner_s = cand_s[GW-1:0];
         end else begin
            found_s  = found_s;
         end
      end
   end

   always_comb begin
      state_d            = state_q;
      grant_d            = grant_q;
      last_grant_d       = last_grant_q;
      eop_s              = 1'b0;
      axis.m_axis_tdata  = '0;
      axis.m_axis_tkeep  = '0;
      axis.m_axis_tvalid = 1'b0;
      axis.m_axis_tlast  = 1'b0;
      axis.s_axis_tready = '0;
      case (state_q)
         ST_IDLE: begin
            if (found_s) begin
               state_d = ST_BUSY;
               grant_d = winner_s;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            axis.m_axis_tdata              = axis.s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
            axis.m_axis_tkeep              = axis.s_axis_tkeep[grant_q*KEEP_WIDTH +: KEEP_WIDTH];
            axis.m_axis_tvalid             = axis.s_axis_tvalid[grant_q];
            axis.m_axis_tlast              = axis.s_axis_tlast[grant_q];
            axis.s_axis_tready[grant_q]    = axis.m_axis_tready;
            eop_s = axis.s_axis_tvalid[grant_q] & axis.m_axis_tready & axis.s_axis_tlast[grant_q];
            // A stalled or paused source simply keeps the grant; only tlast releases it.
            if (eop_s) begin
               state_d      = ST_IDLE;
               last_grant_d = grant_q;
            end else begin
               state_d      = ST_BUSY;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Arbitration state; last_grant resets to the top port so port 0 wins first.
   always_ff @(posedge user_clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         last_grant_q <= LAST_PORT;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign grant_id = grant_q;
   assign busy     = (state_q == ST_BUSY);

`ifdef TX_ARB_STATS_EN
   logic [NUM_PORTS*32-1:0] pkt_cnt_q, pkt_cnt_d;

   // Completed-packet count for the granted port; wraps naturally at 32 bits.
   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      if (eop_s) begin
         pkt_cnt_d[grant_q*32 +: 32] = pkt_cnt_q[grant_q*32 +: 32] + 32'd1;
      end else begin
         pkt_cnt_d = pkt_cnt_q;
      end
   end

   // Counter storage.
   always_ff @(posedge user_clk or negedge aresetn) begin
      if (!aresetn) begin
         pkt_cnt_q <= '0;
      end else begin
         pkt_cnt_q <= pkt_cnt_d;
      end
   end

   assign pkt_cnt = pkt_cnt_q;
`endif
endmodule
